mult_div_unit: RTL and testbench

Iterative RV32M multiply/divide unit that executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU off the main pipeline. It sits directly upstream of the register file and drives its secondary write port (`we_mult_div` / `waddr_mult_div` / `wdata_mult_div`). Because the register file gives its main write port priority, the unit holds its result until the main pipeline leaves the write port free. It also exposes its pending destination register so issue logic can stall dependent reads.

---
 rtl/mult_div_unit.sv | 180 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative RV32M multiply/divide unit feeding the register file's
//            secondary write port. Optional macro: MULT_DIV_FAST_MUL_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd,
    input  logic            kill,
    input  logic            wb_blocked,
    output logic            busy,
    output logic            pend_valid,
    output logic [4:0]      pend_rd,
    output logic            wb_we,
    output logic [4:0]      wb_waddr,
    output logic [XLEN-1:0] wb_wdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_REM    = 3'b110;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [4:0]  r_rd;
    logic [2:0]  r_op;
    logic [31:0] r_b;
    logic [63:0] r_acc;
    logic        r_neg_p;
    logic        r_neg_r;
    logic [31:0] r_result;

    logic        w_accept;
    logic        w_sgn1;
    logic        w_sgn2;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic        w_div0;
    logic        w_ovf;
    logic [31:0] w_special_res;
    logic        w_fast_mul;
    logic [31:0] w_fast_res;
    logic        w_short;

    assign w_accept = start && (r_state == S_IDLE) && !kill;
    assign w_sgn1   = rs1_val[31] && (op == c_OP_MULH || op == c_OP_MULHSU ||
                                      op == c_OP_DIV  || op == c_OP_REM);
    assign w_sgn2   = rs2_val[31] && (op == c_OP_MULH || op == c_OP_DIV || op == c_OP_REM);
    assign w_mag1   = w_sgn1 ? (~rs1_val + 32'd1) : rs1_val;
    assign w_mag2   = w_sgn2 ? (~rs2_val + 32'd1) : rs2_val;

    assign w_div0 = op[2] && (rs2_val == 32'd0);
    assign w_ovf  = (op == c_OP_DIV || op == c_OP_REM) &&
                    (rs1_val == 32'h8000_0000) && (rs2_val == 32'hFFFF_FFFF);
    assign w_special_res = w_div0 ? (op[1] ? rs1_val : 32'hFFFF_FFFF)
                                  : (op[1] ? 32'd0   : 32'h8000_0000);

`ifdef MULT_DIV_FAST_MUL_EN
    // 33x33 signed product, carried in 64 bits: only the low 64 product bits are needed
    logic signed [63:0] w_fa;
    logic signed [63:0] w_fb;
    logic signed [63:0] w_fprod;
    assign w_fa       = {{32{w_sgn1 ? rs1_val[31] : 1'b0}}, rs1_val};
    assign w_fb       = {{32{w_sgn2 ? rs2_val[31] : 1'b0}}, rs2_val};
    assign w_fprod    = w_fa * w_fb;
    assign w_fast_mul = !op[2];
    assign w_fast_res = (op[1:0] == 2'b00) ? w_fprod[31:0] : w_fprod[63:32];
`else
    assign w_fast_mul = 1'b0;
    assign w_fast_res = 32'd0;
`endif

    assign w_short = w_div0 || w_ovf || w_fast_mul;

    // One iteration. Multiply: {partial product, remaining multiplier bits}
    // shifts right. Divide: {partial remainder, dividend/quotient} shifts left.
    logic [32:0] w_sum;
    logic [63:0] w_mul_next;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [63:0] w_div_next;
    logic [63:0] w_step;

    assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
    assign w_mul_next = {w_sum, r_acc[31:1]};
    assign w_ge       = r_acc[63:31] >= {1'b0, r_b};
    assign w_diff     = r_acc[62:31] - r_b;
    assign w_div_next = w_ge ? {w_diff, r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};
    assign w_step     = r_op[2] ? w_div_next : w_mul_next;

    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic [31:0] w_final;

    assign w_prod  = r_neg_p ? (~w_step + 64'd1) : w_step;
    assign w_quo   = r_neg_p ? (~w_step[31:0] + 32'd1) : w_step[31:0];
    assign w_rem   = r_neg_r ? (~w_step[63:32] + 32'd1) : w_step[63:32];
    assign w_final = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                             : ((r_op[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = w_short ? S_WB : S_CALC;
            S_CALC: if (r_cnt == 5'd31) w_next = (r_rd == 5'd0) ? S_IDLE : S_WB;
            S_WB:   if (!wb_blocked) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (kill) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_rd     <= 5'd0;
            r_op     <= 3'd0;
            r_b      <= 32'd0;
            r_acc    <= 64'd0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_op    <= op;
            r_rd    <= rd;
            r_cnt   <= 5'd0;
            r_neg_p <= w_sgn1 ^ w_sgn2;
            r_neg_r <= w_sgn1;
            r_b     <= op[2] ? w_mag2 : w_mag1;
            r_acc   <= {32'd0, op[2] ? w_mag1 : w_mag2};
            if (w_short) begin
                r_result <= (w_div0 || w_ovf) ? w_special_res : w_fast_res;
            end
        end else if (r_state == S_CALC) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
                r_result <= w_final;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign pend_valid = busy && (r_rd != 5'd0);
    assign pend_rd    = r_rd;
    assign wb_we      = (r_state == S_WB);
    assign wb_waddr   = r_rd;
    assign wb_wdata   = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Self-checking bench for mult_div_unit (directed table, random ops
//            against an arithmetic reference, and abort/reset sequences).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1_val = 32'd0;
    logic [31:0] rs2_val = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        kill = 1'b0;
    logic        wb_blocked = 1'b0;
    logic        busy;
    logic        pend_valid;
    logic [4:0]  pend_rd;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .rd         (rd),
        .kill       (kill),
        .wb_blocked (wb_blocked),
        .busy       (busy),
        .pend_valid (pend_valid),
        .pend_rd    (pend_rd),
        .wb_we      (wb_we),
        .wb_waddr   (wb_waddr),
        .wb_wdata   (wb_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          nblock;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULT_DIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    task automatic wait_idle();
        for (int i = 0; i < 80 && busy; i++) tick();
    endtask

    // Issue one op (cycle 0 = start cycle); optionally fire a stray start at cycle ss
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input int nblock,
                          input logic [31:0] exp, input int ss);
        int cyc;
        wait_idle();
        op = f; rs1_val = a; rs2_val = b; rd = d; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        check({tag, " busy@1"}, 32'(busy), 32'd1);
        check({tag, " pend_valid@1"}, 32'(pend_valid), 32'd1);
        check({tag, " pend_rd"}, 32'(pend_rd), 32'(d));
        while (!wb_we && cyc < 60) begin
            if (cyc == ss) begin
                start = 1'b1; op = 3'd0; rs1_val = $urandom; rs2_val = $urandom; rd = 5'd9;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat_of(f, a, b)));
        check({tag, " waddr"}, 32'(wb_waddr), 32'(d));
        check({tag, " wdata"}, wb_wdata, exp);
        for (int i = 0; i < nblock; i++) begin
            wb_blocked = 1'b1;
            tick();
            check({tag, " held we"}, 32'(wb_we), 32'd1);
            check({tag, " held waddr"}, 32'(wb_waddr), 32'(d));
            check({tag, " held wdata"}, wb_wdata, exp);
        end
        wb_blocked = 1'b0;
        tick();
        check({tag, " busy after write"}, 32'(busy), 32'd0);
        check({tag, " we after write"}, 32'(wb_we), 32'd0);
    endtask

    initial begin
        int we_seen;
        int pv_seen;
        logic busy32;
        logic busy33;
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  0, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  0, 32'hFFFF_FFFE};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,         5'd7,  0, 32'hFFFF_FFFF};
        vecs[3]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd8,  0, 32'hFFFF_FFFD};
        vecs[4]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd9,  0, 32'hFFFF_FFFF};
        vecs[5]  = '{3'd5, 32'd100,        32'd7,         5'd10, 0, 32'd14};
        vecs[6]  = '{3'd7, 32'd100,        32'd7,         5'd11, 0, 32'd2};
        vecs[7]  = '{3'd5, 32'd5,          32'd0,         5'd12, 0, 32'hFFFF_FFFF};
        vecs[8]  = '{3'd6, 32'd5,          32'd0,         5'd13, 0, 32'd5};
        vecs[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 0, 32'h8000_0000};
        vecs[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 0, 32'd0};
        vecs[11] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd16, 3, 32'h4000_0000};
        vecs[12] = '{3'd7, 32'hFFFF_FFFF,  32'h10,        5'd17, 2, 32'hF};

        rst = 1'b1;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset pend_valid", 32'(pend_valid), 32'd0);
        check("reset pend_rd", 32'(pend_rd), 32'd0);
        check("reset wb_we", 32'(wb_we), 32'd0);
        check("reset wb_waddr", 32'(wb_waddr), 32'd0);
        check("reset wb_wdata", wb_wdata, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].nblock, vecs[i].exp, 0);
        end

        // Stray start mid-operation must not disturb the running DIVU
        run_op("ignored start", 3'd5, 32'd100, 32'd7, 5'd5, 0, 32'd14, 10);

        for (int i = 0; i < 24; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op($sformatf("rand%0d op%0d", i, rf), rf, ra, rb, 5'($urandom_range(1, 31)),
                   int'($urandom_range(0, 2)), ref_model(rf, ra, rb), 0);
        end

        // rd = 0: result discarded, never visible as pending
        wait_idle();
        op = 3'd5; rs1_val = 32'd1000; rs2_val = 32'd3; rd = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        we_seen = 0; pv_seen = 0; busy32 = 1'b0; busy33 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            if (wb_we) we_seen++;
            if (pend_valid) pv_seen++;
            if (c == 32) busy32 = busy;
            if (c == 33) busy33 = busy;
            tick();
        end
        check("rd0 busy@32", 32'(busy32), 32'd1);
        check("rd0 busy@33", 32'(busy33), 32'd0);
        check("rd0 wb_we count", 32'(we_seen), 32'd0);
        check("rd0 pend_valid count", 32'(pv_seen), 32'd0);

        // kill in cycle 15 of a DIV
        wait_idle();
        op = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3; rd = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 15; c++) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill busy@16", 32'(busy), 32'd0);
        we_seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (wb_we) we_seen++;
            tick();
        end
        check("kill wb_we count", 32'(we_seen), 32'd0);

        // rst while holding a write in WB
        op = 3'd5; rs1_val = 32'd5; rs2_val = 32'd0; rd = 5'd3; start = 1'b1;
        wb_blocked = 1'b1;
        tick();
        start = 1'b0;
        check("rstwb we@1", 32'(wb_we), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wb_blocked = 1'b0;
        check("rstwb busy", 32'(busy), 32'd0);
        check("rstwb pend_valid", 32'(pend_valid), 32'd0);
        check("rstwb pend_rd", 32'(pend_rd), 32'd0);
        check("rstwb wb_we", 32'(wb_we), 32'd0);
        check("rstwb wb_waddr", 32'(wb_waddr), 32'd0);
        check("rstwb wb_wdata", wb_wdata, 32'd0);

        // kill and start together in IDLE: not accepted
        op = 3'd5; rs1_val = 32'd5; rs2_val = 32'd0; rd = 5'd4; start = 1'b1; kill = 1'b1;
        tick();
        start = 1'b0; kill = 1'b0;
        check("kill+start busy", 32'(busy), 32'd0);
        check("kill+start wb_we", 32'(wb_we), 32'd0);
        tick();
        check("kill+start wb_we later", 32'(wb_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
